// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the hex glyph table, segment order {g,f,e,d,c,b,a}, 1 = lit.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h00;

  localparam seg7_t SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    return SEG7_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to 7-segment glyph lookup; the caller registers the result.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg7_decode(nibble);

endmodule

// File: rtl/display_7_seg_mux.sv
// Time-multiplexed N-digit hex display driver with dead-time blanking and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining DISPLAY_7_SEG_LZB_EN.
module display_7_seg_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_HZ           = 16000000,
  parameter int REFRESH_HZ       = 250,
  parameter int DEAD_CYCLES      = 16,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PW       = $clog2(TICK_DIV);
  localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_DEAD = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_nx;
  logic [PW-1:0]           prescaler, prescaler_nx;
  logic [IW-1:0]           index, index_nx;
  logic [4*NUM_DIGITS-1:0] pending_value, shown_value, shown_value_nx;
  logic [NUM_DIGITS-1:0]   pending_dp, shown_dp, shown_dp_nx;
  logic                    pending_valid;
  logic                    pre_wrap, commit;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   onehot, keep, en_nx;

  // Outputs are registered from next-state values so they line up with the slot position.
  always_comb begin
    pre_wrap     = (prescaler == PRE_LAST);
    prescaler_nx = pre_wrap ? '0 : prescaler + 1'b1;
    index_nx     = index;
    commit       = 1'b0;
    if (pre_wrap) begin
      if (index == IDX_LAST) begin
        index_nx = '0;
        commit   = 1'b1;
      end else begin
        index_nx = index + 1'b1;
      end
    end

    shown_value_nx = shown_value;
    shown_dp_nx    = shown_dp;
    if (commit && pending_valid) begin
      shown_value_nx = pending_value;
      shown_dp_nx    = pending_dp;
    end

    case (state)
      BLANK:   state_nx = (prescaler_nx >= PRE_DEAD) ? SHOW : BLANK;
      SHOW:    state_nx = (pre_wrap && HAS_DEAD) ? BLANK : SHOW;
      default: state_nx = BLANK;
    endcase

    cur_nibble = shown_value_nx[{index_nx, 2'b00} +: 4];
    onehot     = '0;
    onehot[index_nx] = 1'b1;
    en_nx      = (state_nx == SHOW) ? (onehot & keep) : '0;
  end

`ifdef DISPLAY_7_SEG_LZB_EN
  // Scan downward: a digit stays visible once any nonzero nibble or lit dp exists at or above it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    keep = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc     = acc | (shown_value_nx[4*k +: 4] != 4'h0) | shown_dp_nx[k];
      keep[k] = acc | (k == 0);
    end
  end
`else
  assign keep = '1;
`endif

  seg7_hex_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // A load in the commit cycle becomes the next pending value; the commit used the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BLANK;
      prescaler     <= '0;
      index         <= '0;
      pending_value <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shown_value   <= '0;
      shown_dp      <= '0;
      seg           <= SEG7_BLANK;
      seg_dp        <= 1'b0;
      digit_en      <= EN_OFF;
      frame_tick    <= 1'b0;
    end else begin
      state       <= state_nx;
      prescaler   <= prescaler_nx;
      index       <= index_nx;
      shown_value <= shown_value_nx;
      shown_dp    <= shown_dp_nx;
      if (load) begin
        pending_value <= value;
        pending_dp    <= dp;
        pending_valid <= 1'b1;
      end else if (commit) begin
        pending_valid <= 1'b0;
      end
      seg        <= dec_seg;
      seg_dp     <= shown_dp_nx[index_nx];
      digit_en   <= en_nx ^ EN_OFF;
      frame_tick <= commit;
    end
  end

endmodule

// File: tb/tb_display_7_seg_mux.sv
// Self-checking bench for display_7_seg_mux: table vectors plus tearing, double-load and reset sequences.
// Build with DISPLAY_7_SEG_LZB_EN defined to check leading-zero blanking.
module tb_display_7_seg_mux;

  localparam int NUM_DIGITS  = 4;
  localparam int CLK_HZ      = 8000;
  localparam int REFRESH_HZ  = 250;
  localparam int DEAD_CYCLES = 2;
  localparam int SLOT        = 8;
  localparam int FRAME       = SLOT * NUM_DIGITS;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       ft;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  vis_lzb;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];

  display_7_seg_mux #(
    .NUM_DIGITS       (NUM_DIGITS),
    .CLK_HZ           (CLK_HZ),
    .REFRESH_HZ       (REFRESH_HZ),
    .DEAD_CYCLES      (DEAD_CYCLES),
    .DIGIT_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lzb(input logic [3:0] mask);
`ifdef DISPLAY_7_SEG_LZB_EN
    return mask;
`else
    return mask | 4'hF;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Expected outputs for frame positions first..last; position 0 is the frame_tick cycle.
  task automatic pushFrame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] vis,
                           input int first, input int last, input bit after_reset);
    exp_t e;
    logic [3:0] nib;
    for (int c = first; c <= last; c++) begin
      int k, pos;
      k   = c / SLOT;
      pos = c % SLOT;
      nib = v[4*k +: 4];
      e.seg = GLYPH[nib];
      e.dp  = d[k];
      e.en  = (pos < DEAD_CYCLES || !vis[k]) ? 4'hF : ~(4'b0001 << k);
      e.ft  = (c == 0) && !after_reset;
      if (after_reset && c == 0) begin
        e.seg = 7'h00;
        e.dp  = 1'b0;
        e.en  = 4'hF;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    value = v.value;
    dp    = v.dp;
    load  = 1'b1;
    pushFrame(v.value, v.dp, lzb(v.vis_lzb), 0, FRAME - 1, 1'b0);
    step();
  endtask

  task automatic checkOutput(input string name);
    exp_t e, got;
    got = {seg, seg_dp, digit_en, frame_tick};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: output seg=%h dp=%b en=%b ft=%b, required an expected entry (queue empty)",
               name, seg, seg_dp, digit_en, frame_tick);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s: got seg=%h dp=%b en=%b ft=%b, expected seg=%h dp=%b en=%b ft=%b",
               name, seg, seg_dp, digit_en, frame_tick, e.seg, e.dp, e.en, e.ft);
    end
  endtask

  task automatic checkFrom(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s[%0d]", name, i));
      if (i < n - 1) step();
    end
  endtask

  task automatic waitFrameTick(input string name);
    bit seen;
    seen = 1'b0;
    checks++;
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      seen = frame_tick;
    end
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: frame_tick=0 after 80 cycles, expected 1", name);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b1111};
    vecs[1] = '{16'h5678, 4'b0001, 4'b1111};
    vecs[2] = '{16'h9ABC, 4'b0000, 4'b1111};
    vecs[3] = '{16'hDEF0, 4'b1000, 4'b1111};
    vecs[4] = '{16'h0F00, 4'b0100, 4'b0111};
    vecs[5] = '{16'h0005, 4'b0000, 4'b0001};
    vecs[6] = '{16'h0000, 4'b0000, 4'b0001};
    vecs[7] = '{16'h0030, 4'b0001, 4'b0011};
    vecs[8] = '{16'h0000, 4'b0100, 4'b0111};

    $display("[TB] start");
    reset = 1'b1;
    repeat (3) step();
    pushFrame(16'h0000, 4'b0000, lzb(4'b0001), 0, FRAME - 1, 1'b1);
    reset = 1'b0;
    checkFrom(FRAME, "post_reset");
    pushFrame(16'h0000, 4'b0000, lzb(4'b0001), 0, FRAME - 1, 1'b0);
    step();
    checkFrom(FRAME, "first_frame");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      waitFrameTick($sformatf("vec%0d_tick", i));
      checkFrom(FRAME, $sformatf("vec%0d", i));
    end

    // Load during digit 2: the rest of this frame keeps the old value.
    applyStimulus('{16'h1234, 4'b0000, 4'b1111});
    waitFrameTick("tear_tick");
    checkFrom(16, "tear_lo");
    step();
    value = 16'hABCD;
    dp    = 4'b0000;
    load  = 1'b1;
    checkFrom(16, "tear_hi");
    pushFrame(16'hABCD, 4'b0000, 4'hF, 0, FRAME - 1, 1'b0);
    step();
    checkFrom(FRAME, "tear_new");

    // Two loads within one frame: only the second is ever committed.
    pushFrame(16'hABCD, 4'b0000, 4'hF, 0, FRAME - 1, 1'b0);
    step();
    checkFrom(5, "two_loads_a");
    step();
    value = 16'h1111;
    load  = 1'b1;
    checkFrom(15, "two_loads_b");
    step();
    value = 16'h2222;
    load  = 1'b1;
    checkFrom(12, "two_loads_c");
    pushFrame(16'h2222, 4'b0000, 4'hF, 0, FRAME - 1, 1'b0);
    step();
    checkFrom(FRAME, "two_loads_new");
    pushFrame(16'h2222, 4'b0000, 4'hF, 0, FRAME - 1, 1'b0);
    step();
    checkFrom(FRAME, "two_loads_hold");

    // Reset while digit 2 is lit, with a load still pending.
    pushFrame(16'h2222, 4'b0000, 4'hF, 0, 18, 1'b0);
    step();
    checkFrom(10, "pre_reset_a");
    step();
    value = 16'h7777;
    load  = 1'b1;
    checkFrom(9, "pre_reset_b");
    reset = 1'b1;
    pushFrame(16'h0000, 4'b0000, lzb(4'b0001), 0, FRAME - 1, 1'b1);
    step();
    reset = 1'b0;
    checkFrom(FRAME, "reset_abort");
    pushFrame(16'h0000, 4'b0000, lzb(4'b0001), 0, FRAME - 1, 1'b0);
    step();
    checkFrom(FRAME, "reset_pending_cleared");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
